// File: rtl/alu_unit.sv
// RV32I integer execute unit: ALU/branch-compare evaluation feeding an in-order output queue.
// Define ALU_MUL_EN to add a two-cycle multiplier on op[4:3]=11; otherwise those ops return 0.
module alu_unit #(
  parameter int XLEN           = 32,
  parameter int ROB_SIZE_WIDTH = 4,
  parameter int QUEUE_AW       = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROB_SIZE_WIDTH-1:0] in_rob_id,
  input  logic [4:0]                in_op,
  input  logic [XLEN-1:0]           in_v1,
  input  logic [XLEN-1:0]           in_v2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROB_SIZE_WIDTH-1:0] out_rob_id,
  output logic [XLEN-1:0]           out_result,
  output logic                      o_dbg_state
);
  // Handshakes: a transfer happens on a posedge where valid && ready; valid never waits on ready.
  localparam int DEPTH = 2 ** QUEUE_AW;
  localparam int SHW   = $clog2(XLEN);
  localparam logic [QUEUE_AW:0]   CNT_FULL = (QUEUE_AW + 1)'(DEPTH);
  localparam logic [QUEUE_AW:0]   CNT_ONE  = 1;
  localparam logic [QUEUE_AW-1:0] PTR_ONE  = 1;

  function automatic logic [XLEN-1:0] f_alu(input logic [4:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    logic           bit_res;
    logic [XLEN-1:0] res;
    sh      = b[SHW-1:0];
    bit_res = 1'b0;
    res     = '0;
    if (op[4] && !op[3]) begin
      case (op[2:0])
        3'b000:  bit_res = (a == b);
        3'b001:  bit_res = (a != b);
        3'b100:  bit_res = ($signed(a) <  $signed(b));
        3'b101:  bit_res = ($signed(a) >= $signed(b));
        3'b110:  bit_res = (a <  b);
        3'b111:  bit_res = (a >= b);
        default: bit_res = 1'b0;
      endcase
      res = XLEN'(bit_res);
    end else if (!op[4]) begin
      case (op[2:0])
        3'b000:  res = op[3] ? (a - b) : (a + b);
        3'b001:  res = a << sh;
        3'b010:  res = XLEN'($signed(a) < $signed(b));
        3'b011:  res = XLEN'(a < b);
        3'b100:  res = a ^ b;
        3'b101:  res = op[3] ? XLEN'($signed(a) >>> sh) : (a >> sh);
        3'b110:  res = a | b;
        default: res = a & b;
      endcase
    end
    return res;
  endfunction

  logic [XLEN-1:0]           r_data [DEPTH];
  logic [ROB_SIZE_WIDTH-1:0] r_rob  [DEPTH];
  logic [QUEUE_AW-1:0]       r_wptr, r_rptr;
  logic [QUEUE_AW:0]         r_count;

  logic                      w_accept, w_pop, w_push, w_is_mul, w_mul_busy, w_mul_done;
  logic [XLEN-1:0]           w_push_data;
  logic [ROB_SIZE_WIDTH-1:0] w_push_rob;

  assign in_ready   = rdy && !w_mul_busy && (r_count != CNT_FULL);
  assign out_valid  = rdy && (r_count != '0);
  assign out_rob_id = r_rob[r_rptr];
  assign out_result = r_data[r_rptr];
  assign w_accept   = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE = 1'b0, S_MUL1 = 1'b1} state_t;
  state_t                    r_state;
  logic [2:0]                r_mop;
  logic [XLEN-1:0]           r_ma, r_mb;
  logic [ROB_SIZE_WIDTH-1:0] r_mrob;
  logic [2*XLEN-1:0]         w_ea, w_eb, w_prod;
  logic [XLEN-1:0]           w_mul_res;

  // Operand extension selects the signedness; the low 2*XLEN bits of the product are exact.
  assign w_ea      = (r_mop[1:0] != 2'b11) ? {{XLEN{r_ma[XLEN-1]}}, r_ma} : {{XLEN{1'b0}}, r_ma};
  assign w_eb      = (r_mop[1:0] == 2'b01) ? {{XLEN{r_mb[XLEN-1]}}, r_mb} : {{XLEN{1'b0}}, r_mb};
  assign w_prod    = w_ea * w_eb;
  assign w_mul_res = r_mop[2] ? '0 :
                     (r_mop[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign w_is_mul    = (in_op[4:3] == 2'b11);
  assign w_mul_busy  = (r_state == S_MUL1);
  assign w_mul_done  = (r_state == S_MUL1);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mop   <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_mrob  <= '0;
    end else if (rdy) begin
      if (clear) begin
        r_state <= S_IDLE;
      end else if (r_state == S_MUL1) begin
        r_state <= S_IDLE;
      end else if (w_accept && w_is_mul) begin
        r_state <= S_MUL1;
        r_mop   <= in_op[2:0];
        r_ma    <= in_v1;
        r_mb    <= in_v2;
        r_mrob  <= in_rob_id;
      end
    end
  end
`else
  logic [XLEN-1:0] w_mul_res;
  logic [ROB_SIZE_WIDTH-1:0] r_mrob;
  assign w_mul_res   = '0;
  assign r_mrob      = '0;
  assign w_is_mul    = 1'b0;
  assign w_mul_busy  = 1'b0;
  assign w_mul_done  = 1'b0;
  assign o_dbg_state = 1'b0;
`endif

  // A multiply completes only while no new accept is possible, so the two push sources never collide.
  assign w_push      = (w_accept && !w_is_mul) || w_mul_done;
  assign w_push_data = w_mul_done ? w_mul_res : f_alu(in_op, in_v1, in_v2);
  assign w_push_rob  = w_mul_done ? r_mrob : in_rob_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_rob[i]  <= '0;
      end
    end else if (rdy) begin
      if (clear) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_data[r_wptr] <= w_push_data;
          r_rob[r_wptr]  <= w_push_rob;
          r_wptr         <= r_wptr + PTR_ONE;
        end
        if (w_pop) r_rptr <= r_rptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit: reset, op coverage, queue full/ordering, clear and freeze.
module tb_alu_unit;
  logic        clk = 1'b0;
  logic        rst, rdy, clear, in_valid, in_ready, out_valid, out_ready, dbg_state;
  logic [3:0]  in_rob_id, out_rob_id;
  logic [4:0]  in_op;
  logic [31:0] in_v1, in_v2, out_result;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       tag;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  alu_unit #(.XLEN(32), .ROB_SIZE_WIDTH(4), .QUEUE_AW(1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_rob_id(in_rob_id),
    .in_op(in_op), .in_v1(in_v1), .in_v2(in_v2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rob_id(out_rob_id), .out_result(out_result),
    .o_dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] rob);
    in_valid  = 1'b1;
    in_op     = op;
    in_v1     = a;
    in_v2     = b;
    in_rob_id = rob;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [3:0] rob, input logic [31:0] res);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_rob"}, 32'(out_rob_id), 32'(rob));
    check({tag, "_result"}, out_result, res);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_v1 = '0; in_v2 = '0; in_rob_id = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_rob", 32'(out_rob_id), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic add, one-cycle latency, pop drains the queue
    push(5'b00000, 32'd5, 32'd7, 4'd3);
    pop_check("add", 4'd3, 32'd12);
    check("add_drained", 32'(out_valid), 32'd0);

    tbl.push_back('{5'b01101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra"});
    tbl.push_back('{5'b10110, 32'h0000_0001, 32'hFFFF_FFFF, 32'd1, "bltu"});
    tbl.push_back('{5'b10100, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0, "blt"});
    tbl.push_back('{5'b01000, 32'd5, 32'd7, 32'hFFFF_FFFE, "sub"});
    tbl.push_back('{5'b00001, 32'd1, 32'd33, 32'd2, "sll"});
    tbl.push_back('{5'b00010, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt"});
    tbl.push_back('{5'b00011, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu"});
    tbl.push_back('{5'b00100, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, "xor"});
    tbl.push_back('{5'b00101, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl"});
    tbl.push_back('{5'b00110, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, "or"});
    tbl.push_back('{5'b00111, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, "and"});
    tbl.push_back('{5'b10000, 32'd9, 32'd9, 32'd1, "beq"});
    tbl.push_back('{5'b10001, 32'd9, 32'd9, 32'd0, "bne"});
    tbl.push_back('{5'b10101, 32'hFFFF_FFFF, 32'd1, 32'd0, "bge"});
    tbl.push_back('{5'b10111, 32'hFFFF_FFFF, 32'd1, 32'd1, "bgeu"});
    tbl.push_back('{5'b10010, 32'd1, 32'd2, 32'd0, "br010"});
    tbl.push_back('{5'b00000, 32'hFFFF_FFFF, 32'd2, 32'd1, "add_wrap"});
    foreach (tbl[i]) begin
      push(tbl[i].op, tbl[i].a, tbl[i].b, 4'(i));
      pop_check(tbl[i].tag, 4'(i), tbl[i].exp);
    end

    // Fill the queue, hold a third request, then drain in order
    push(5'b00000, 32'd1, 32'd1, 4'd1);
    push(5'b00000, 32'd2, 32'd2, 4'd2);
    in_valid = 1'b1; in_op = 5'b00000; in_v1 = 32'd3; in_v2 = 32'd3; in_rob_id = 4'd3;
    check("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("full_hold_head", 32'(out_rob_id), 32'd1);
    out_ready = 1'b1;
    #1;
    check("full_no_bypass", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    #1;
    check("after_pop_in_ready", 32'(in_ready), 32'd1);
    check("after_pop_head", 32'(out_rob_id), 32'd2);
    tick();
    in_valid = 1'b0;
    pop_check("order_b", 4'd2, 32'd4);
    pop_check("order_c", 4'd3, 32'd6);
    check("order_drained", 32'(out_valid), 32'd0);

    // Clear on a full queue with push and pop requested
    push(5'b00000, 32'd1, 32'd1, 4'd1);
    push(5'b00000, 32'd2, 32'd2, 4'd2);
    in_valid = 1'b1; clear = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    #1;
    check("clear_full_valid", 32'(out_valid), 32'd0);
    check("clear_full_ready", 32'(in_ready), 32'd1);
    push(5'b00000, 32'd4, 32'd4, 4'd4);
    in_valid = 1'b1; in_rob_id = 4'd5; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    check("clear_push_dropped", 32'(out_valid), 32'd0);
    push(5'b00000, 32'd2, 32'd2, 4'd6);
    pop_check("post_clear", 4'd6, 32'd4);

    // rdy=0 freezes the queue and masks both handshakes
    push(5'b00000, 32'd1, 32'd1, 4'd7);
    rdy = 1'b0; in_valid = 1'b1; in_rob_id = 4'd8; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("freeze_out_valid", 32'(out_valid), 32'd0);
      check("freeze_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    rdy = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    pop_check("freeze_kept", 4'd7, 32'd2);
    check("freeze_no_push", 32'(out_valid), 32'd0);

`ifdef ALU_MUL_EN
    in_valid = 1'b1; in_op = 5'b11011; in_v1 = 32'hFFFF_FFFF; in_v2 = 32'hFFFF_FFFF; in_rob_id = 4'd5;
    tick();
    in_valid = 1'b0;
    check("mulhu_busy", 32'(in_ready), 32'd0);
    check("mulhu_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("mulhu_ready_again", 32'(in_ready), 32'd1);
    pop_check("mulhu", 4'd5, 32'hFFFF_FFFE);
    push(5'b11000, 32'd3, 32'd4, 4'd9);
    tick();
    pop_check("mul", 4'd9, 32'd12);
    push(5'b11001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10);
    tick();
    pop_check("mulh", 4'd10, 32'd0);
    push(5'b11010, 32'hFFFF_FFFF, 32'd2, 4'd11);
    tick();
    pop_check("mulhsu", 4'd11, 32'hFFFF_FFFF);
    push(5'b11000, 32'd6, 32'd7, 4'd12);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("mul_clear_ready", 32'(in_ready), 32'd1);
    check("mul_clear_valid", 32'(out_valid), 32'd0);
    tick();
    check("mul_clear_no_push", 32'(out_valid), 32'd0);
`else
    push(5'b11000, 32'd3, 32'd4, 4'd9);
    check("nomul_in_ready", 32'(in_ready), 32'd1);
    pop_check("nomul", 4'd9, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
